auto_corner_detector: RTL

// - Upstream of the manual corner-adjust stage. Scans one video frame of thresholded marker pixels and finds

---
 rtl/corner_pkg.sv | 42 ++++
 rtl/corner_extreme_tracker.sv | 57 +++++
 rtl/auto_corner_detector.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/corner_pkg.sv
// Shared types and helpers for the auto corner detector.
// Contents: coordinate/bus widths, corner index constants, tracker
// metric/direction selectors, FSM state enum, and pack/unpack helpers for
// the 80-bit {TLx,TLy,TRx,TRy,BRx,BRy,BLx,BLy} corner bus.
// Optional macro: CORNER_SMOOTH_EN adds the ACCUM2 state.
package corner_pkg;

   localparam int unsigned COORD_W     = 10;
   localparam int unsigned POINT_W     = 2 * COORD_W;
   localparam int unsigned NUM_CORNERS = 4;
   localparam int unsigned BUS_W       = NUM_CORNERS * POINT_W;

   localparam int unsigned TL = 0;
   localparam int unsigned TR = 1;
   localparam int unsigned BR = 2;
   localparam int unsigned BL = 3;

   typedef enum logic {METRIC_SUM, METRIC_DIFF} metric_e;
   typedef enum logic {DIR_MIN, DIR_MAX}        dir_e;

`ifdef CORNER_SMOOTH_EN
   typedef enum logic [2:0] {IDLE, ARMED, ACCUM, ACCUM2, HOLD} state_e;
`else
   typedef enum logic [1:0] {IDLE, ARMED, ACCUM, HOLD} state_e;
`endif

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   // TL lands in the top bits, BL in the bottom bits.
   function automatic logic [BUS_W-1:0] pack_corners(input point_t tl, input point_t tr,
                                                     input point_t br, input point_t bl);
      return {tl, tr, br, bl};
   endfunction

   function automatic point_t unpack_corner(input logic [BUS_W-1:0] bus, input int unsigned idx);
      return point_t'(bus[BUS_W-1-idx*POINT_W -: POINT_W]);
   endfunction

endpackage

// File: rtl/corner_extreme_tracker.sv
// Tracks the extreme point of one metric over a frame.
// Ports: clk, reset_n (async, active-low), clear (sync re-init), en (qualified
// pixel this cycle), x/y (pixel coordinate), best (stored extreme point).
// METRIC selects x+y (unsigned) or x-y (signed); DIR selects min or max.
// Strict compare keeps the earliest pixel on ties.
module corner_extreme_tracker
   import corner_pkg::*;
#(
   parameter metric_e METRIC = METRIC_SUM,
   parameter dir_e    DIR    = DIR_MIN
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               en,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output point_t             best
);

   localparam int unsigned M_W = COORD_W + 2;

   // Sentinel that any real pixel beats on the first strict compare.
   localparam logic signed [M_W-1:0] INIT_M =
      (METRIC == METRIC_SUM) ?
         ((DIR == DIR_MIN) ? M_W'(2 ** (COORD_W + 1) - 1) : M_W'(0)) :
         ((DIR == DIR_MIN) ? M_W'(2 ** COORD_W - 1)       : M_W'(-(2 ** COORD_W)));

   logic [COORD_W:0]        sum_c;
   logic [COORD_W:0]        diff_c;
   logic signed [M_W-1:0]   metric_c;
   logic signed [M_W-1:0]   best_m;
   logic                    better_c;

   // Metric of the current pixel and strict comparison against the stored best.
   always_comb begin
      sum_c    = {1'b0, x} + {1'b0, y};
      diff_c   = {1'b0, x} - {1'b0, y};
      metric_c = (METRIC == METRIC_SUM) ? $signed({1'b0, sum_c})
                                        : $signed({diff_c[COORD_W], diff_c});
      better_c = (DIR == DIR_MIN) ? (metric_c < best_m) : (metric_c > best_m);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         best_m <= INIT_M;
         best   <= '0;
      end else if (clear) begin
         best_m <= INIT_M;
         best   <= '0;
      end else if (en && better_c) begin
         best_m <= metric_c;
         best   <= point_t'({x, y});
      end
   end

endmodule

// File: rtl/auto_corner_detector.sv
// Scans one frame of thresholded marker pixels and publishes the four extreme
// points TL=min(x+y), TR=max(x-y), BR=max(x+y), BL=min(x-y) for the manual
// corner-adjust stage.
// Ports: clk, reset_n (async, active-low), field (frame toggle, rising edge =
// frame boundary), pixel_valid/hcount/vcount/pixel_on (pixel stream),
// capture (detection request), auto_corners (80-bit corner bus), set_corners
// (load strobe spanning one field rising edge), busy (not IDLE), detect_fail
// (one-cycle pulse on too few marker pixels).
// Optional macro: CORNER_SMOOTH_EN averages the result of two consecutive frames.
module auto_corner_detector
   import corner_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned MIN_PIXELS = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               field,
   input  logic               pixel_valid,
   input  logic [COORD_W-1:0] hcount,
   input  logic [COORD_W-1:0] vcount,
   input  logic               pixel_on,
   input  logic               capture,
   output logic [BUS_W-1:0]   auto_corners,
   output logic               set_corners,
   output logic               busy,
   output logic               detect_fail
);

   localparam int unsigned CNT_W = 16;

   state_e             state;
   logic               field_q;
   logic [CNT_W-1:0]   count;
   logic               fedge_c;
   logic               in_accum_c;
   logic               qual_c;
   logic               clear_c;
   logic               count_low_c;
   logic [BUS_W-1:0]   live_bus_c;
   point_t             best_pt [NUM_CORNERS];

   // Frame edge, pixel qualification and tracker re-init. A pixel on the
   // fedge cycle belongs to the next frame and is never accumulated.
   always_comb begin
      fedge_c     = field & ~field_q;
`ifdef CORNER_SMOOTH_EN
      in_accum_c  = (state == ACCUM) || (state == ACCUM2);
      clear_c     = fedge_c && ((state == ARMED) || (state == ACCUM));
`else
      in_accum_c  = (state == ACCUM);
      clear_c     = fedge_c && (state == ARMED);
`endif
      qual_c      = in_accum_c && !fedge_c && pixel_valid && pixel_on &&
                    (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
      count_low_c = 32'(count) < MIN_PIXELS;
      live_bus_c  = pack_corners(best_pt[TL], best_pt[TR], best_pt[BR], best_pt[BL]);
   end

   corner_extreme_tracker #(.METRIC(METRIC_SUM), .DIR(DIR_MIN)) u_tl (
      .clk(clk), .reset_n(reset_n), .clear(clear_c), .en(qual_c),
      .x(hcount), .y(vcount), .best(best_pt[TL]));
   corner_extreme_tracker #(.METRIC(METRIC_DIFF), .DIR(DIR_MAX)) u_tr (
      .clk(clk), .reset_n(reset_n), .clear(clear_c), .en(qual_c),
      .x(hcount), .y(vcount), .best(best_pt[TR]));
   corner_extreme_tracker #(.METRIC(METRIC_SUM), .DIR(DIR_MAX)) u_br (
      .clk(clk), .reset_n(reset_n), .clear(clear_c), .en(qual_c),
      .x(hcount), .y(vcount), .best(best_pt[BR]));
   corner_extreme_tracker #(.METRIC(METRIC_DIFF), .DIR(DIR_MIN)) u_bl (
      .clk(clk), .reset_n(reset_n), .clear(clear_c), .en(qual_c),
      .x(hcount), .y(vcount), .best(best_pt[BL]));

`ifdef CORNER_SMOOTH_EN
   logic [BUS_W-1:0] frame_a;
   logic [BUS_W-1:0] smooth_bus_c;
   point_t           a_pt;

   // Rounded mean of two coordinates through an 11-bit intermediate.
   function automatic logic [COORD_W-1:0] avg2(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
      logic [COORD_W:0] s;
      s = (COORD_W+1)'(a) + (COORD_W+1)'(b) + (COORD_W+1)'(1);
      return s[COORD_W:1];
   endfunction

   // Per-field average of frame A (saved) and frame B (live trackers).
   always_comb begin
      smooth_bus_c = '0;
      a_pt         = '0;
      for (int unsigned i = 0; i < NUM_CORNERS; i++) begin
         a_pt = unpack_corner(frame_a, i);
         smooth_bus_c[BUS_W-1-i*POINT_W -: POINT_W] =
            {avg2(a_pt.x, best_pt[i].x), avg2(a_pt.y, best_pt[i].y)};
      end
   end
`endif

   // Control FSM, marker counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         field_q      <= 1'b0;
         count        <= '0;
         auto_corners <= '0;
         set_corners  <= 1'b0;
         busy         <= 1'b0;
         detect_fail  <= 1'b0;
`ifdef CORNER_SMOOTH_EN
         frame_a      <= '0;
`endif
      end else begin
         field_q     <= field;
         detect_fail <= 1'b0;

         // Saturating marker count.
         if (clear_c) begin
            count <= '0;
         end else if (qual_c && (count != '1)) begin
            count <= count + CNT_W'(1);
         end

         case (state)
            IDLE: begin
               if (capture) begin
                  state <= ARMED;
                  busy  <= 1'b1;
               end
            end
            ARMED: begin
               if (fedge_c) begin
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (fedge_c) begin
                  if (count_low_c) begin
                     detect_fail <= 1'b1;
                     state       <= IDLE;
                     busy        <= 1'b0;
                  end else begin
`ifdef CORNER_SMOOTH_EN
                     frame_a      <= live_bus_c;
                     state        <= ACCUM2;
`else
                     auto_corners <= live_bus_c;
                     set_corners  <= 1'b1;
                     state        <= HOLD;
`endif
                  end
               end
            end
`ifdef CORNER_SMOOTH_EN
            ACCUM2: begin
               if (fedge_c) begin
                  if (count_low_c) begin
                     detect_fail <= 1'b1;
                     state       <= IDLE;
                     busy        <= 1'b0;
                  end else begin
                     auto_corners <= smooth_bus_c;
                     set_corners  <= 1'b1;
                     state        <= HOLD;
                  end
               end
            end
`endif
            HOLD: begin
               // Strobe stays up until the consumer has seen one fedge.
               if (fedge_c) begin
                  set_corners <= 1'b0;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               set_corners <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
